// File: rtl/vslc_scan_sequencer_if.sv
// Signal bundle between the scan sequencer and its surroundings (pins and VSLC executor).
// instr_ready is a valid-only strobe: the executor always accepts, so there is no ready back-pressure.
interface vslc_scan_sequencer_if #(
    parameter int AW = 5
);
    logic          run;
    logic [7:0]    ui_in;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [AW:0]   prog_len;
    logic [7:0]    instr;
    logic          instr_ready;
    logic [7:0]    ui_snap;
    logic [7:0]    ui_prev;
    logic          scan_done;
    logic          busy;
    logic          overrun;
    logic          wr_err;
    logic [15:0]   scan_count;

    modport master (
        output run, ui_in, prog_we, prog_addr, prog_data, prog_len,
        input  instr, instr_ready, ui_snap, ui_prev, scan_done, busy,
               overrun, wr_err, scan_count
    );

    modport slave (
        input  run, ui_in, prog_we, prog_addr, prog_data, prog_len,
        output instr, instr_ready, ui_snap, ui_prev, scan_done, busy,
               overrun, wr_err, scan_count
    );
endinterface

// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle controller: snapshots inputs, streams the stored ladder program to the
// executor one byte per cycle, and paces scans at SCAN_DIV clocks with overrun detection.
module vslc_scan_sequencer #(
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vslc_scan_sequencer_if.slave  bus,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [15:0] DIV_M1  = 16'(SCAN_DIV - 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [7:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   pc_nxt;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    instr_q, instr_d;
    logic          instr_ready_q, instr_ready_d;
    logic [7:0]    ui_snap_q, ui_snap_d;
    logic [7:0]    ui_prev_q, ui_prev_d;
    logic          scan_done_q, scan_done_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          wr_err_q, wr_err_d;
    logic [15:0]   scan_count_q, scan_count_d;

    // The store is only writable while idle so a scan always sees a stable program.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state_q == S_IDLE) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        ui_snap_d    = ui_snap_q;
        ui_prev_d    = ui_prev_q;
        overrun_d    = overrun_q;
        scan_count_d = scan_count_q;
        pc_nxt       = {1'b0, pc_q} + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_LATCH;
            end
            S_LATCH: begin
                ui_prev_d = ui_snap_q;
                ui_snap_d = bus.ui_in;
                pc_d      = '0;
                len_d     = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
                state_d   = (len_d != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (pc_nxt == len_q) state_d = S_DONE;
                else                 pc_d    = pc_nxt[AW-1:0];
            end
            S_DONE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q >= DIV_M1) state_d = bus.run ? S_LATCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Cycle counter restarts at every scan start and saturates rather than wrapping.
        if (state_d == S_LATCH)                       cnt_d = '0;
        else if (state_q != S_IDLE && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        else                                          cnt_d = cnt_q;

        instr_ready_d = (state_d == S_ISSUE);
        instr_d       = instr_ready_d ? mem[pc_d] : 8'h00;
        scan_done_d   = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE);
        wr_err_d      = bus.prog_we && (state_q != S_IDLE);

        if (state_d == S_DONE) begin
            scan_count_d = scan_count_q + 16'd1;
            if (cnt_d >= DIV_M1) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_ready_q <= 1'b0;
            ui_snap_q     <= '0;
            ui_prev_q     <= '0;
            scan_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            wr_err_q      <= 1'b0;
            scan_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            ui_snap_q     <= ui_snap_d;
            ui_prev_q     <= ui_prev_d;
            scan_done_q   <= scan_done_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            wr_err_q      <= wr_err_d;
            scan_count_q  <= scan_count_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_ready = instr_ready_q;
    assign bus.ui_snap     = ui_snap_q;
    assign bus.ui_prev     = ui_prev_q;
    assign bus.scan_done   = scan_done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.scan_count  = scan_count_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Scoreboard bench for vslc_scan_sequencer with SCAN_DIV = 10.
module tb_vslc_scan_sequencer;
    localparam int AW  = 5;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] state_dbg;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    vslc_scan_sequencer_if #(.AW(AW)) bus ();

    vslc_scan_sequencer #(.DEPTH(32), .AW(AW), .SCAN_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q[$];
    logic [32:0] exp_done_q[$];
    int          latch_q[$];

    logic [7:0]  mem_model [32];
    logic [7:0]  m_snap, m_prev;
    logic [15:0] m_count;
    logic        m_ovr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an instruction or a scan end.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL instr_unexpected: got %0h with nothing expected", bus.instr);
                end else begin
                    check("instr", bus.instr, exp_q.pop_front());
                end
            end else begin
                check("instr_idle_zero", bus.instr, 0);
            end
            if (bus.scan_done) begin
                if (exp_done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scan_done_unexpected: got count %0h with nothing expected", bus.scan_count);
                end else begin
                    check("scan_end{count,ovr,snap,prev}",
                          {bus.scan_count, bus.overrun, bus.ui_snap, bus.ui_prev},
                          exp_done_q.pop_front());
                end
            end
            if (state_dbg == 3'd1) latch_q.push_back(cyc);
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_instr"}, bus.instr, 0);
        check({tag, "_instr_ready"}, bus.instr_ready, 0);
        check({tag, "_ui_snap"}, bus.ui_snap, 0);
        check({tag, "_ui_prev"}, bus.ui_prev, 0);
        check({tag, "_scan_done"}, bus.scan_done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_wr_err"}, bus.wr_err, 0);
        check({tag, "_scan_count"}, bus.scan_count, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic write_mem(input int a, input logic [7:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a[4:0];
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    // Runs n scans (run held high until the n-th LATCH), ui_in = u0 then u1.
    task automatic run_scans(input int n, input int len, input logic [7:0] u0,
                             input logic [7:0] u1, input bit inj_wr);
        int len_eff, per, lat, dn, guard, wr_pend;
        bit inj_done;
        len_eff = (len > 32) ? 32 : len;
        per     = (len_eff + 2 >= DIV) ? len_eff + 3 : DIV;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < len_eff; i++) exp_q.push_back(mem_model[i]);
            m_prev  = m_snap;
            m_snap  = (k == 0) ? u0 : u1;
            m_count = m_count + 16'd1;
            if (len_eff + 2 >= DIV) m_ovr = 1'b1;
            exp_done_q.push_back({m_count, m_ovr, m_snap, m_prev});
        end
        latch_q.delete();
        bus.prog_len = 6'(len);
        bus.ui_in    = u0;
        bus.run      = 1'b1;
        lat = 0; dn = 0; guard = 0; wr_pend = 0; inj_done = 1'b0;
        while ((dn < n || state_dbg != 3'd0) && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (wr_pend == 2) begin
                check("wr_err_pulse", bus.wr_err, 1);
                bus.prog_we = 1'b0;
                wr_pend = 1;
            end else if (wr_pend == 1) begin
                check("wr_err_clear", bus.wr_err, 0);
                wr_pend = 0;
            end
            if (inj_wr && !inj_done && state_dbg == 3'd2) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = 5'd1;
                bus.prog_data = 8'hFF;
                wr_pend  = 2;
                inj_done = 1'b1;
            end
            if (state_dbg == 3'd1) begin
                lat++;
                if (lat == n) bus.run = 1'b0;
            end
            if (bus.scan_done) begin
                dn++;
                bus.ui_in = u1;
            end
        end
        bus.prog_we = 1'b0;
        if (guard >= 2000) begin
            tests++;
            fails++;
            $display("FAIL scan_timeout: got %0d scans expected %0d", dn, n);
        end
        check("instr_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        check("latch_count", latch_q.size(), n);
        for (int i = 1; i < latch_q.size(); i++)
            check("scan_period", latch_q[i] - latch_q[i-1], per);
        check("busy_after", bus.busy, 0);
    endtask

    initial begin
        int iss, guard;
        bus.run = 1'b0; bus.ui_in = 8'h00; bus.prog_we = 1'b0;
        bus.prog_addr = '0; bus.prog_data = 8'h00; bus.prog_len = '0;
        m_snap = 8'h00; m_prev = 8'h00; m_count = 16'd0; m_ovr = 1'b0;

        #1 rst_n = 1'b0;
        #20;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Program load: three known opcodes then a distinct pattern for the clamp tests.
        for (int i = 0; i < 32; i++) mem_model[i] = 8'(i * 29 + 7);
        mem_model[0] = 8'h00; mem_model[1] = 8'h81; mem_model[2] = 8'h10;
        for (int i = 0; i < 32; i++) write_mem(i, mem_model[i]);
        check("wr_err_idle_write", bus.wr_err, 0);

        run_scans(1, 3, 8'h11, 8'h11, 1'b0);
        check("single_overrun", bus.overrun, 0);
        check("single_count", bus.scan_count, 1);

        run_scans(2, 3, 8'hA5, 8'h5A, 1'b0);
        run_scans(1, 0, 8'h3C, 8'h3C, 1'b0);
        run_scans(1, 3, 8'h77, 8'h77, 1'b1);
        run_scans(1, 3, 8'h78, 8'h78, 1'b0);
        run_scans(2, 32, 8'h01, 8'h02, 1'b0);
        check("overrun_sticky", bus.overrun, 1);
        run_scans(1, 40, 8'h04, 8'h04, 1'b0);

        // Reset in the middle of ISSUE: only the first two instructions appear.
        exp_q.push_back(mem_model[0]);
        exp_q.push_back(mem_model[1]);
        bus.prog_len = 6'd3;
        bus.ui_in    = 8'h99;
        bus.run      = 1'b1;
        iss = 0; guard = 0;
        while (iss < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (state_dbg == 3'd2) iss++;
        end
        check("midscan_issue_seen", iss, 2);
        #2 rst_n = 1'b0;
        #1 check_quiet("midscan_reset");
        check("midscan_queue", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        m_snap = 8'h00; m_prev = 8'h00; m_count = 16'd0; m_ovr = 1'b0;
        rst_n = 1'b1;
        run_scans(1, 3, 8'hC3, 8'hC3, 1'b0);
        check("post_reset_count", bus.scan_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
